// File: rtl/assoc_matcher_pkg.sv
// Shared types and sizing helpers for the associative flow matcher.
// Holds the FSM state enum, byte/word constants and KW/VW derivation.
package assoc_matcher_pkg;

  localparam int FLOW_TAG_LEN = 2;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    IDLE,
    HASH,
    KEY,
    VAL,
    DONE
  } state_e;

  function automatic int key_words(input int key_bytes);
    return (FLOW_TAG_LEN + key_bytes + WORD_BYTES - 1) / WORD_BYTES;
  endfunction

  function automatic int val_words(input int val_bytes);
    return val_bytes / WORD_BYTES;
  endfunction

endpackage

// File: rtl/assoc_matcher_hash.sv
// Bucket hash: XOR-fold of the 8 key bytes into an 8-bit bucket index.
// Ports: clk, rst (async low), start_i, key_i[63:0] -> ready_o pulse, hash_o.
module assoc_matcher_hash (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [63:0] key_i,
  output logic        ready_o,
  output logic [31:0] hash_o
);

  logic        ready_q, ready_d;
  logic [31:0] hash_q, hash_d;
  logic [7:0]  fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < 8; i++) begin
      fold = fold ^ key_i[8*i +: 8];
    end
    ready_d = start_i;
    hash_d  = start_i ? {24'h0, fold} : hash_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      hash_q  <= '0;
    end else begin
      ready_q <= ready_d;
      hash_q  <= hash_d;
    end
  end

  assign ready_o = ready_q;
  assign hash_o  = hash_q;

endmodule

// File: rtl/assoc_matcher.sv
// Hashed multi-way flow lookup: probes WAYS entries of one bucket word by word.
// Ports: lookup start/key, config load, 32-bit read port, done/hit/way/value.
module assoc_matcher
  import assoc_matcher_pkg::*;
#(
  parameter logic [15:0] PROC_ID   = 16'h0000,
  parameter int          KEY_BYTES = 6,
  parameter int          VAL_BYTES = 16,
  parameter int          WAYS      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic                   busy_o,
  input  logic                   mod_start_i,
  input  logic [31:0]            mod_entry_len_i,
  input  logic [31:0]            mod_start_addr_i,
  output logic                   mem_ce_o,
  output logic [31:0]            mem_addr_o,
  input  logic [31:0]            mem_data_i,
  input  logic                   mem_ready_i,
  output logic                   ready_o,
  output logic                   is_match_o,
  output logic [2:0]             way_o,
  output logic [8*VAL_BYTES-1:0] val_o
);

  localparam int KW   = key_words(KEY_BYTES);
  localparam int VW   = val_words(VAL_BYTES);
  localparam int KB   = KW * 32;
  localparam int VB   = VW * 32;
  localparam int PADB = KB - 8 * (FLOW_TAG_LEN + KEY_BYTES);

  localparam logic [4:0] KW_LAST  = 5'(KW - 1);
  localparam logic [4:0] VW_LAST  = 5'(VW - 1);
  localparam logic [2:0] WAY_LAST = 3'(WAYS - 1);

  state_e         state_q, state_d;
  logic [KB-1:0]  key_q, key_d;
  logic [31:0]    len_q, len_d;
  logic [31:0]    sa_q, sa_d;
  logic [31:0]    base_q, base_d;
  logic [31:0]    addr_q, addr_d;
  logic [4:0]     wcnt_q, wcnt_d;
  logic [2:0]     way_q, way_d;
  logic [2:0]     hway_q, hway_d;
  logic           match_q, match_d;
  logic           ce_q, ce_d;
  logic           hstart_q, hstart_d;
  logic [VB-1:0]  val_q, val_d;

  logic [63:0]    hash_key;
  logic           hash_rdy;
  logic [31:0]    hash_val;
  logic [31:0]    kword;
  logic [VB-1:0]  vword;

  // First 8 bytes of the tagged key; short keys are zero-extended.
  assign hash_key = 64'({key_q, 64'h0} >> KB);

  assoc_matcher_hash u_hash (
    .clk     (clk),
    .rst     (rst),
    .start_i (hstart_q),
    .key_i   (hash_key),
    .ready_o (hash_rdy),
    .hash_o  (hash_val)
  );

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    len_d    = len_q;
    sa_d     = sa_q;
    base_d   = base_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    way_d    = way_q;
    hway_d   = hway_q;
    match_d  = match_q;
    ce_d     = ce_q;
    hstart_d = 1'b0;
    val_d    = val_q;
    kword    = 32'((key_q << {wcnt_q, 5'b0}) >> (KB - 32));
    vword    = (VB'(mem_data_i) << (VB - 32)) >> {wcnt_q, 5'b0};

    unique case (state_q)
      IDLE: begin
        if (mod_start_i) begin
          len_d = mod_entry_len_i;
          sa_d  = mod_start_addr_i;
        end else if (start_i) begin
          key_d    = KB'({PROC_ID, key_i}) << PADB;
          val_d    = '0;
          match_d  = 1'b0;
          hway_d   = '0;
          way_d    = '0;
          wcnt_d   = '0;
          hstart_d = 1'b1;
          state_d  = HASH;
        end
      end
      HASH: begin
        if (hash_rdy) begin
          base_d  = sa_q + hash_val * (32'(WAYS) * len_q);
          addr_d  = base_d;
          ce_d    = 1'b1;
          wcnt_d  = '0;
          state_d = KEY;
        end
      end
      KEY: begin
        if (mem_ready_i) begin
          if (mem_data_i == kword) begin
            addr_d = addr_q + 32'd4;
            if (wcnt_q == KW_LAST) begin
              wcnt_d  = '0;
              state_d = VAL;
            end else begin
              wcnt_d = wcnt_q + 5'd1;
            end
          end else if (way_q != WAY_LAST) begin
            way_d  = way_q + 3'd1;
            wcnt_d = '0;
            addr_d = base_q + (32'(way_q) + 32'd1) * len_q;
          end else begin
            ce_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      VAL: begin
        if (mem_ready_i) begin
          val_d  = val_q | vword;
          addr_d = addr_q + 32'd4;
          if (wcnt_q == VW_LAST) begin
            ce_d    = 1'b0;
            match_d = 1'b1;
            hway_d  = way_q;
            state_d = DONE;
          end else begin
            wcnt_d = wcnt_q + 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      len_q    <= '0;
      sa_q     <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      way_q    <= '0;
      hway_q   <= '0;
      match_q  <= 1'b0;
      ce_q     <= 1'b0;
      hstart_q <= 1'b0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      len_q    <= len_d;
      sa_q     <= sa_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      way_q    <= way_d;
      hway_q   <= hway_d;
      match_q  <= match_d;
      ce_q     <= ce_d;
      hstart_q <= hstart_d;
      val_q    <= val_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign ready_o    = (state_q == DONE);
  assign mem_ce_o   = ce_q;
  assign mem_addr_o = addr_q;
  assign is_match_o = match_q;
  assign way_o      = hway_q;
  assign val_o      = val_q;

endmodule

// File: tb/tb_assoc_matcher.sv
// Scoreboard bench for assoc_matcher against a word-memory reference model.
// Random keys, bucket contents and memory stalls; monitor checks every read and result.
module tb_assoc_matcher;
  import assoc_matcher_pkg::*;

  localparam logic [15:0] PID  = 16'hA5C3;
  localparam int KEYB = 6;
  localparam int VALB = 16;
  localparam int WAYS = 4;
  localparam int KW   = key_words(KEYB);
  localparam int VW   = val_words(VALB);
  localparam int HLAT = 2;

  logic              clk, rst;
  logic              start_i, busy_o, mod_start_i;
  logic [8*KEYB-1:0] key_i;
  logic [31:0]       mod_entry_len_i, mod_start_addr_i;
  logic              mem_ce_o, mem_ready_i;
  logic [31:0]       mem_addr_o, mem_data_i;
  logic              ready_o, is_match_o;
  logic [2:0]        way_o;
  logic [8*VALB-1:0] val_o;

  assoc_matcher #(
    .PROC_ID(PID), .KEY_BYTES(KEYB), .VAL_BYTES(VALB), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .key_i(key_i), .busy_o(busy_o),
    .mod_start_i(mod_start_i), .mod_entry_len_i(mod_entry_len_i),
    .mod_start_addr_i(mod_start_addr_i),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .ready_o(ready_o), .is_match_o(is_match_o),
    .way_o(way_o), .val_o(val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              hit;
    logic [2:0]        way;
    logic [8*VALB-1:0] val;
    int                nreads;
    int                t0;
    bit                chk_lat;
  } exp_t;

  logic [31:0] mem [int unsigned];
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        last;
  int          n_cmp, n_bad, cyc, reads_since;
  bit          rand_rdy, prev_rdy;
  logic [31:0] cfg_base, cfg_len;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] bucket(input logic [47:0] k);
    logic [63:0] f;
    logic [7:0]  h;
    f = {PID, k};
    h = '0;
    for (int i = 0; i < 8; i++) h = h ^ f[8*i +: 8];
    return cfg_base + 32'(h) * 32'(WAYS) * cfg_len;
  endfunction

  function automatic logic [31:0] kword(input logic [47:0] k, input int i);
    logic [63:0] f;
    f = {PID, k};
    return f[63-32*i -: 32];
  endfunction

  // Fill one bucket: hitw is the first full-key way (WAYS = none).
  task automatic setup(input logic [47:0] k, input int hitw, input bit w0miss);
    logic [31:0] a, base;
    int m;
    base = bucket(k);
    for (int w = 0; w < WAYS; w++) begin
      a = base + 32'(w) * cfg_len;
      if (w == hitw || (w > hitw && $urandom_range(0, 1) == 1)) m = KW;
      else m = w0miss ? 0 : $urandom_range(0, KW - 1);
      for (int i = 0; i < KW; i++) begin
        if (i < m)       mem[a + 32'(4*i)] = kword(k, i);
        else if (i == m) mem[a + 32'(4*i)] = kword(k, i) ^ ($urandom | 32'h1);
        else             mem[a + 32'(4*i)] = $urandom;
      end
      for (int j = 0; j < VW; j++) mem[a + 32'(4*(KW+j))] = $urandom;
    end
  endtask

  task automatic model_push(input logic [47:0] k, input bit lat);
    exp_t e;
    logic [31:0] a, base;
    bit ok;
    e.hit = 1'b0; e.way = '0; e.val = '0; e.nreads = 0;
    base = bucket(k);
    for (int w = 0; w < WAYS && !e.hit; w++) begin
      a  = base + 32'(w) * cfg_len;
      ok = 1'b1;
      for (int i = 0; i < KW && ok; i++) begin
        addr_q.push_back(a + 32'(4*i));
        e.nreads++;
        if (rd(a + 32'(4*i)) != kword(k, i)) ok = 1'b0;
      end
      if (ok) begin
        e.hit = 1'b1;
        e.way = 3'(w);
        for (int j = 0; j < VW; j++) begin
          addr_q.push_back(a + 32'(4*(KW+j)));
          e.val[8*VALB-1-32*j -: 32] = rd(a + 32'(4*(KW+j)));
          e.nreads++;
        end
      end
    end
    e.t0 = cyc;
    e.chk_lat = lat;
    exp_q.push_back(e);
    last = e;
  endtask

  task automatic issue(input logic [47:0] k, input bit lat);
    @(posedge clk); #1;
    chk("idle_at_start", 128'(busy_o), 128'(0));
    start_i = 1'b1;
    key_i = k;
    reads_since = 0;
    model_push(k, lat);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      addr_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("hold_match", 128'(is_match_o), 128'(last.hit));
    chk("hold_val", 128'(val_o), 128'(last.val));
    chk("idle_after", 128'(busy_o), 128'(0));
  endtask

  task automatic load_cfg(input logic [31:0] b, input logic [31:0] l);
    @(posedge clk); #1;
    mod_start_i = 1'b1;
    mod_start_addr_i = b;
    mod_entry_len_i = l;
    @(posedge clk); #1;
    mod_start_i = 1'b0;
    cfg_base = b;
    cfg_len = l;
  endtask

  // Memory responder: random stalls with garbage data when not ready.
  initial begin
    mem_ready_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_data_i = (mem_ready_i && mem_ce_o) ? rd(mem_addr_o) : $urandom;
    end
  end

  // Monitor: checks every consumed read address and every result.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_ce_o && mem_ready_i) begin
        reads_since++;
        if (addr_q.size() > 0) begin
          chk("rd_addr", 128'(mem_addr_o), 128'(addr_q.pop_front()));
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL extra_read: got addr %0h expected no read", mem_addr_o);
        end
      end
      if (ready_o && prev_rdy) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_width: got 2+ cycles expected 1");
      end
      if (ready_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_ready: got ready expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("is_match", 128'(is_match_o), 128'(e.hit));
          chk("way", 128'(way_o), 128'(e.way));
          chk("val", 128'(val_o), 128'(e.val));
          chk("ce_in_done", 128'(mem_ce_o), 128'(0));
          chk("reads", 128'(reads_since), 128'(e.nreads));
          chk("addr_left", 128'(addr_q.size()), 128'(0));
          addr_q.delete();
          if (e.chk_lat)
            chk("latency", 128'(cyc - e.t0 + 1), 128'(1 + HLAT + e.nreads + 1));
        end
      end
      prev_rdy = ready_o;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  initial begin
    logic [47:0] k;
    int hw, lim;
    n_cmp = 0; n_bad = 0; cyc = 0; reads_since = 0;
    rand_rdy = 1'b0; prev_rdy = 1'b0;
    cfg_base = '0; cfg_len = '0;
    rst = 1'b0; start_i = 1'b0; mod_start_i = 1'b0; key_i = '0;
    mod_entry_len_i = '0; mod_start_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_ready", 128'(ready_o), 128'(0));
    chk("rst_ce", 128'(mem_ce_o), 128'(0));
    chk("rst_addr", 128'(mem_addr_o), 128'(0));
    chk("rst_match", 128'(is_match_o), 128'(0));
    chk("rst_val", 128'(val_o), 128'(0));
    rst = 1'b1;

    load_cfg(32'h1000, 32);
    k = {$urandom, 16'($urandom)};
    setup(k, 0, 1'b0); issue(k, 1'b1); wait_done();
    k = {$urandom, 16'($urandom)};
    setup(k, 3, 1'b1); issue(k, 1'b1); wait_done();
    k = {$urandom, 16'($urandom)};
    setup(k, WAYS, 1'b0); issue(k, 1'b1); wait_done();
    rand_rdy = 1'b1;
    k = {$urandom, 16'($urandom)};
    setup(k, 1, 1'b0); issue(k, 1'b0); wait_done();

    for (int n = 0; n < 14; n++) begin
      if (n == 7) load_cfg(32'hFFFF_FF80, 40);
      rand_rdy = ($urandom_range(0, 1) == 1);
      hw = $urandom_range(0, WAYS);
      k = {$urandom, 16'($urandom)};
      setup(k, hw, ($urandom_range(0, 1) == 1));
      issue(k, !rand_rdy);
      wait_done();
    end

    // Config load wins over a same-cycle lookup request.
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    mod_start_i = 1'b1; start_i = 1'b1;
    mod_start_addr_i = 32'h0002_0000; mod_entry_len_i = 48;
    @(posedge clk); #1;
    mod_start_i = 1'b0; start_i = 1'b0;
    cfg_base = 32'h0002_0000; cfg_len = 48;
    chk("no_lookup_on_cfg", 128'(busy_o), 128'(0));
    k = {$urandom, 16'($urandom)};
    setup(k, 2, 1'b0); issue(k, 1'b1);
    // Requests while busy are ignored.
    start_i = 1'b1; key_i = ~k; mod_start_i = 1'b1;
    mod_start_addr_i = 32'h0300_0000; mod_entry_len_i = 64;
    @(posedge clk); #1;
    start_i = 1'b0; mod_start_i = 1'b0;
    wait_done();
    k = {$urandom, 16'($urandom)};
    setup(k, 1, 1'b0); issue(k, 1'b1); wait_done();

    // Reset while filling the value words.
    load_cfg(32'h1000, 32);
    k = {$urandom, 16'($urandom)};
    setup(k, 0, 1'b0); issue(k, 1'b0);
    lim = 0;
    while (reads_since < KW + 1 && lim < 50) begin
      @(posedge clk); #1;
      lim++;
    end
    chk("reached_val", 128'(reads_since >= KW + 1), 128'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy_o), 128'(0));
    chk("mid_rst_ce", 128'(mem_ce_o), 128'(0));
    chk("mid_rst_addr", 128'(mem_addr_o), 128'(0));
    chk("mid_rst_val", 128'(val_o), 128'(0));
    chk("mid_rst_ready", 128'(ready_o), 128'(0));
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    load_cfg(32'h1000, 32);
    k = {$urandom, 16'($urandom)};
    setup(k, 0, 1'b0); issue(k, 1'b1); wait_done();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
